// File: rtl/log_fir_pkg.sv
// log_fir_pkg: definitions shared by the log-domain FIR slice.
//   fir_state_t   - sequencer states for log_fir_seq
//   sat_to_width  - clamps a signed 64-bit value to the two's-complement
//                   range of a w-bit word (w <= 64)
package log_fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } fir_state_t;

    function automatic logic signed [63:0] sat_to_width(
        input logic signed [63:0] v,
        input int unsigned        w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/log_fir_taps.sv
// log_fir_taps: bank of ORD parallel log-domain (Mitchell) multipliers.
// Each tap product is |x|*|w| approximated as 2^(kx+kw) * (1 + fx + fw),
// renormalised when fx + fw >= 1; exact whenever either operand is a power
// of two. The product is scaled back by QP+SHIFT fractional bits, truncated
// toward zero and saturated to WIDTH bits.
// Ports:
//   i_x_packed  in   ORD*WIDTH  samples, tap i at [WIDTH*i +: WIDTH]
//   i_w_packed  in   ORD*WIDTH  weights, same packing
//   o_p_packed  out  ORD*WIDTH  saturated products, same packing
// Operand width is limited to WIDTH <= 21 so the unscaled mantissa fits 64 bits.
module log_fir_taps
    import log_fir_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned QP    = 12,
    parameter int unsigned ORD   = 4,
    parameter int unsigned SHIFT = 0
) (
    input  logic [ORD*WIDTH-1:0] i_x_packed,
    input  logic [ORD*WIDTH-1:0] i_w_packed,
    output logic [ORD*WIDTH-1:0] o_p_packed
);

    function automatic logic [WIDTH-1:0] log_mul(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        [63:0] ma;
        logic        [63:0] mb;
        logic        [63:0] fa;
        logic        [63:0] fb;
        logic        [63:0] s;
        logic        [63:0] mant;
        logic        [63:0] raw;
        logic        [63:0] mag;
        logic signed [63:0] res;
        int unsigned        ka;
        int unsigned        kb;
        int unsigned        e;
        logic               neg;

        sa  = 64'($signed(a));
        sb  = 64'($signed(b));
        ma  = sa[63] ? 64'(-sa) : 64'(sa);
        mb  = sb[63] ? 64'(-sb) : 64'(sb);
        neg = a[WIDTH-1] ^ b[WIDTH-1];

        // Characteristic: index of the leading one.
        ka = 0;
        kb = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (ma[i]) ka = i;
            if (mb[i]) kb = i;
        end

        // Mantissa fractions normalised to WIDTH fractional bits.
        fa = (ma ^ (64'd1 << ka)) << (WIDTH - ka);
        fb = (mb ^ (64'd1 << kb)) << (WIDTH - kb);
        s  = fa + fb;

        // A carry out of the fraction sum bumps the exponent; in both cases
        // the mantissa is 1.s[WIDTH-1:0].
        e    = ka + kb + 32'(s[WIDTH]);
        mant = (64'd1 << WIDTH) | (s & ((64'd1 << WIDTH) - 64'd1));
        raw  = mant << e;
        mag  = raw >> (WIDTH + QP + SHIFT);
        if (ma == 64'd0 || mb == 64'd0) mag = 64'd0;

        res = neg ? -$signed(mag) : $signed(mag);
        return WIDTH'(sat_to_width(res, WIDTH));
    endfunction

    for (genvar t = 0; t < ORD; t++) begin : g_tap
        assign o_p_packed[t*WIDTH +: WIDTH] =
            log_mul(i_x_packed[t*WIDTH +: WIDTH], i_w_packed[t*WIDTH +: WIDTH]);
    end

endmodule

// File: rtl/log_fir_seq.sv
// log_fir_seq: time-multiplexed log-domain FIR. One operand set (ORD samples
// and ORD weights) is captured, pushed LANES taps per cycle through a shared
// log_fir_taps bank, accumulated, saturated to WIDTH bits and presented on a
// valid/ready output. Input and output transactions never overlap.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready operand-set handshake (in_ready high only in IDLE)
//   filter_in_packed  ORD*WIDTH samples, tap i at [WIDTH*i +: WIDTH]
//   weight_in_packed  ORD*WIDTH weights, same packing
//   y_out             saturated sum of products, QP fractional bits
//   out_valid/out_ready result handshake
//   busy              high whenever the sequencer is not IDLE
// ORD must be a multiple of LANES.
module log_fir_seq
    import log_fir_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned QP    = 12,
    parameter int unsigned ORD   = 64,
    parameter int unsigned LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ORD*WIDTH-1:0] filter_in_packed,
    input  logic [ORD*WIDTH-1:0] weight_in_packed,
    output logic [WIDTH-1:0]     y_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int unsigned NG = ORD / LANES;
    localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int unsigned AW = WIDTH + $clog2(ORD) + 1;

    fir_state_t                r_state;
    logic [GW-1:0]             r_g;
    logic [ORD*WIDTH-1:0]      r_x;
    logic [ORD*WIDTH-1:0]      r_w;
    logic [LANES*WIDTH-1:0]    r_prod;
    logic signed [AW-1:0]      r_acc;
    logic [WIDTH-1:0]          r_y;
    logic                      r_out_valid;

    logic [LANES*WIDTH-1:0]    w_lane_x;
    logic [LANES*WIDTH-1:0]    w_lane_w;
    logic [LANES*WIDTH-1:0]    w_lane_p;
    logic signed [AW-1:0]      w_grp_sum;
    logic signed [AW-1:0]      w_acc_next;
    logic [WIDTH-1:0]          w_y_sat;

    // Lane muxes: group g selects taps g*LANES .. g*LANES+LANES-1.
    assign w_lane_x = r_x[r_g*(LANES*WIDTH) +: LANES*WIDTH];
    assign w_lane_w = r_w[r_g*(LANES*WIDTH) +: LANES*WIDTH];

    log_fir_taps #(
        .WIDTH (WIDTH),
        .QP    (QP),
        .ORD   (LANES),
        .SHIFT (0)
    ) u_taps (
        .i_x_packed (w_lane_x),
        .i_w_packed (w_lane_w),
        .o_p_packed (w_lane_p)
    );

    always_comb begin
        w_grp_sum = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_grp_sum = w_grp_sum + AW'($signed(r_prod[l*WIDTH +: WIDTH]));
        end
    end

    assign w_acc_next = r_acc + w_grp_sum;
    assign w_y_sat    = WIDTH'(sat_to_width(64'(w_acc_next), WIDTH));

    // Products registered in RUN are added on the following cycle, so the
    // first RUN cycle adds the zeroed product registers and DRAIN adds the
    // last group while loading the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_g         <= '0;
            r_x         <= '0;
            r_w         <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= filter_in_packed;
                        r_w     <= weight_in_packed;
                        r_g     <= '0;
                        r_acc   <= '0;
                        r_prod  <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_prod <= w_lane_p;
                    r_acc  <= w_acc_next;
                    if (r_g == GW'(NG - 1)) begin
                        r_g     <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_g <= r_g + 1'b1;
                    end
                end
                DRAIN: begin
                    r_acc       <= w_acc_next;
                    r_y         <= w_y_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign y_out     = r_y;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_log_fir_seq.sv
// Self-checking bench for log_fir_seq (WIDTH=16, QP=12, ORD=8, LANES=2).
// Expected results come from a table of hand-derived constants and, for
// random sets, from a real-valued log-domain reference model.
module tb_log_fir_seq;

    localparam int WIDTH = 16;
    localparam int QP    = 12;
    localparam int ORD   = 8;
    localparam int LANES = 2;
    localparam int PW    = ORD * WIDTH;
    localparam int LAT   = ORD / LANES + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] filter_in_packed;
    logic [PW-1:0] weight_in_packed;
    logic [WIDTH-1:0] y_out;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    log_fir_seq #(
        .WIDTH (WIDTH),
        .QP    (QP),
        .ORD   (ORD),
        .LANES (LANES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .filter_in_packed (filter_in_packed),
        .weight_in_packed (weight_in_packed),
        .y_out            (y_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy)
    );

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        for (int i = 0; i < n; i++) r = r * 2.0;
        return r;
    endfunction

    function automatic longint sat_w(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Mitchell product in real arithmetic: log2|v| ~ k + (|v|/2^k - 1),
    // antilog 2^k * (1 + frac), then scaled by 2^-QP toward zero.
    function automatic longint ref_mul(input int a, input int b);
        real    ma, mb, l, p;
        int     ka, kb, k;
        longint mag;
        if (a == 0 || b == 0) return 0;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        ka = 0;
        while (pow2(ka + 1) <= ma) ka++;
        kb = 0;
        while (pow2(kb + 1) <= mb) kb++;
        l   = (ka + (ma / pow2(ka) - 1.0)) + (kb + (mb / pow2(kb) - 1.0));
        k   = int'($floor(l));
        p   = pow2(k) * (1.0 + (l - k));
        mag = longint'($floor(p / pow2(QP)));
        return ((a < 0) != (b < 0)) ? -mag : mag;
    endfunction

    function automatic int model_y(input logic [PW-1:0] xp, input logic [PW-1:0] wp);
        longint acc;
        acc = 0;
        for (int i = 0; i < ORD; i++) begin
            acc += sat_w(ref_mul(int'($signed(xp[i*WIDTH +: WIDTH])),
                                 int'($signed(wp[i*WIDTH +: WIDTH]))));
        end
        return int'(sat_w(acc));
    endfunction

    function automatic logic [PW-1:0] fill(input int v);
        logic [WIDTH-1:0] t;
        t = v[WIDTH-1:0];
        return {ORD{t}};
    endfunction

    function automatic logic [PW-1:0] rand_vec(input int lim);
        logic [PW-1:0] r;
        int            v;
        for (int i = 0; i < ORD; i++) begin
            v = int'($urandom_range(2 * lim)) - lim;
            r[i*WIDTH +: WIDTH] = v[WIDTH-1:0];
        end
        return r;
    endfunction

    // One full transaction, entered #1 after a rising edge with the DUT idle.
    // Latency counts the capture cycle as cycle 0. During a stall the bench
    // offers junk operand sets that must be ignored.
    task automatic do_txn(input string name, input logic [PW-1:0] xp,
                          input logic [PW-1:0] wp, input int exp_y, input int stall);
        int   cyc;
        logic ok;
        check({name, "/ready"}, in_ready, 1);
        filter_in_packed = xp;
        weight_in_packed = wp;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        filter_in_packed = ~xp;
        weight_in_packed = ~wp;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "/latency"}, cyc, LAT);
        check({name, "/y"}, longint'($signed(y_out)), exp_y);
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (!(out_valid && int'($signed(y_out)) == exp_y && !in_ready && busy)) ok = 1'b0;
        end
        if (stall > 0) check({name, "/hold"}, ok, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "/accept"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    typedef struct {
        string name;
        int    xv;
        int    wv;
        int    ey;
        int    stall;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] xa, wa, xb, wb;
        int            ea, eb, cyc, lim;
        logic          seen;

        tbl[0] = '{"x1_w05",     4096,  2048,  16384, 0};
        tbl[1] = '{"xm1_w025",  -4096,  1024,  -8192, 0};
        tbl[2] = '{"sat_pos",    8192,  8192,  32767, 0};
        tbl[3] = '{"sat_neg",   -8192,  8192, -32768, 0};
        tbl[4] = '{"zero_x",        0, 12345,      0, 0};
        tbl[5] = '{"min_exact",  4096, -4096, -32768, 2};
        tbl[6] = '{"approx_075", 3072,  3072,  16384, 5};
        tbl[7] = '{"neg_neg",   -8192, -8192,  32767, 1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        filter_in_packed = '0;
        weight_in_packed = '0;
        #1;
        check("rst/in_ready", in_ready, 1);
        check("rst/busy", busy, 0);
        check("rst/out_valid", out_valid, 0);
        check("rst/y_out", y_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors; the first one also captures on the first edge after reset.
        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].name, fill(tbl[i].xv), fill(tbl[i].wv), tbl[i].ey, tbl[i].stall);
        end

        // Reset during the second RUN cycle discards the set.
        filter_in_packed = fill(4096);
        weight_in_packed = fill(2048);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midrst/busy_run", busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst/in_ready", in_ready, 1);
        check("midrst/busy", busy, 0);
        check("midrst/y_out", y_out, 0);
        #2;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst/no_result", seen, 0);
        do_txn("after_rst", fill(-4096), fill(1024), -8192, 0);

        // Back-to-back with in_valid held high.
        xa = rand_vec(8192);
        wa = rand_vec(8192);
        xb = rand_vec(8192);
        wb = rand_vec(8192);
        ea = model_y(xa, wa);
        eb = model_y(xb, wb);
        filter_in_packed = xa;
        weight_in_packed = wa;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b/lat_a", cyc, LAT);
        check("b2b/y_a", longint'($signed(y_out)), ea);
        filter_in_packed = xb;
        weight_in_packed = wb;
        @(posedge clk); #1;
        check("b2b/idle_after_accept", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b/captured_b", busy, 1);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b/lat_b", cyc, LAT);
        check("b2b/y_b", longint'($signed(y_out)), eb);
        @(posedge clk); #1;
        check("b2b/accept_b", {out_valid, in_ready}, 2'b01);

        // Random operand sets against the reference model.
        for (int n = 0; n < 24; n++) begin
            case (n % 3)
                0:       lim = 256;
                1:       lim = 4096;
                default: lim = 32767;
            endcase
            xa = rand_vec(lim);
            wa = rand_vec(lim);
            do_txn($sformatf("rand%0d", n), xa, wa, model_y(xa, wa),
                   int'($urandom_range(2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/log_fir_seq.md
LOG_FIR_SEQ -- requirements
Module: log_fir_seq

Interface
REQ-001 Parameter WIDTH, 16: sample, weight and output word width, two's complement.
REQ-002 Parameter QP, 12: fractional bits of sample, weight and output.
REQ-003 Parameter ORD, 64: filter order; SHALL be a multiple of LANES.
REQ-004 Parameter LANES, 4: shared log multipliers used per cycle; 1 <= LANES <= ORD.
REQ-005 Port clk  input  1  single clock; all state on rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port in_valid  input  1  operand set offered.
REQ-008 Port in_ready  output  1  block can capture an operand set.
REQ-009 Port filter_in_packed  input  ORD*WIDTH  tap samples; tap i at bits [WIDTH*i +: WIDTH].
REQ-010 Port weight_in_packed  input  ORD*WIDTH  weights, same packing.
REQ-011 Port y_out  output  WIDTH  saturated sum of all tap products, QP fractional bits.
REQ-012 Port out_valid  output  1  y_out holds a result.
REQ-013 Port out_ready  input  1  consumer accepts y_out.
REQ-014 Port busy  output  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, RUN, DRAIN and HOLD, and there SHALL be no other states.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready, capture both packed inputs into internal registers, clear group counter g and accumulator, and go to RUN.
REQ-017 RUN: each cycle, apply taps g*LANES..g*LANES+LANES-1 to the shared multiplier bank and register the LANES products; increment g; after g=ORD/LANES-1, go to DRAIN.
REQ-018 The accumulator SHALL add the sign-extended sum of the registered products one cycle after they are registered.
REQ-019 DRAIN: exactly one cycle; add the last registered group; load the saturated accumulator into y_out; set out_valid; go to HOLD.
REQ-020 Latency: out_valid SHALL rise ORD/LANES+2 cycles after the capture edge (ORD=8, LANES=2 gives 6).
REQ-021 HOLD: y_out and out_valid SHALL stay stable until out_valid&&out_ready; that cycle clears out_valid and returns to IDLE.
REQ-022 in_ready SHALL be 0 in RUN, DRAIN and HOLD; offered inputs there are ignored and the captured operands are unaffected.
REQ-023 The earliest next capture SHALL be the cycle after a result is accepted; there is no input/output overlap.
REQ-024 Accumulator width SHALL be WIDTH+clog2(ORD)+1 bits, signed, with no internal overflow.
REQ-025 The y_out conversion SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-026 Lane products SHALL use the shared datapath's arithmetic unchanged (log-domain approximation; exact for powers of two).
REQ-027 When LANES=ORD, RUN SHALL last one cycle.
REQ-028 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-029 rst SHALL force the state to IDLE, g=0, accumulator=0, product registers=0 and y_out=0.
REQ-030 rst SHALL also force out_valid=0, busy=0 and in_ready=1 (in_ready is a state decode).
REQ-031 Reset asserted mid-RUN or mid-HOLD SHALL discard the operation with no partial result emitted.
REQ-032 After release, the first rising edge SHALL be able to capture an operand set.

Structure
REQ-033 The multiplier bank SHALL be one instance of the existing log_fir_taps with ORD=LANES and SHIFT=0, fed by lane muxes driven from g.
REQ-034 The state encoding and a saturate-to-WIDTH helper SHALL live in the shared package log_fir_pkg; there SHALL be no other sub-modules.

Verification (WIDTH=16, QP=12, ORD=8, LANES=2)
REQ-035 All x=4096 (1.0), all w=2048 (0.5), out_ready=1 -> y_out=16384 (4.0); out_valid rises 6 cycles after capture and lasts 1 cycle.
REQ-036 All x=-4096, all w=1024 (0.25) -> y_out=-8192 (-2.0).
REQ-037 All x=8192, all w=8192 (products 4.0, sum 32.0) -> y_out=32767; with x negated -> y_out=-32768.
REQ-038 out_ready held 0 for 5 cycles after out_valid -> y_out and out_valid stable, in_ready=0, new in_valid ignored; result accepted on the first out_ready=1.
REQ-039 rst pulsed in the 2nd RUN cycle -> out_valid never asserts for that set; in_ready=1 next cycle; a fresh set completes correctly.
REQ-040 Back-to-back sets with in_valid held high -> the second capture occurs exactly 1 cycle after the first result is accepted, and the second result is correct.
